// File: rtl/led_pattern_sequencer.sv
// Table-driven LED pattern sequencer: plays STEPS entries of {pattern, dwell}.
// Supports one-shot or looped playback, table writes in any state, and stop.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | pattern_out holds IDLE_PAT, waiting for start
//  RUN   | driving table entry step_idx, dwell_cnt counting down to 0
module led_pattern_sequencer #(
    parameter int                 WIDTH    = 16,
    parameter int                 STEPS    = 8,
    parameter int                 TW       = 32,
    parameter logic [WIDTH-1:0]   IDLE_PAT = 16'hFF0F,
    localparam int                AW       = $clog2(STEPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [WIDTH-1:0] cfg_pattern,
    input  logic [TW-1:0]    cfg_dwell,
    input  logic [AW-1:0]    cfg_last,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] pattern_out,
    output logic [AW-1:0]    step_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [AW:0]   STEPS_W  = (AW+1)'(STEPS);
    localparam logic [AW-1:0] LAST_MAX = AW'(STEPS - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pat_tbl   [STEPS];
    logic [TW-1:0]    dwell_tbl [STEPS];

    logic [TW-1:0]    dwell_cnt, cnt_nxt;
    logic [AW-1:0]    last_cur, last_nxt;
    logic [WIDTH-1:0] pat_nxt;
    logic [AW-1:0]    idx_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             load;
    logic [AW-1:0]    load_idx;
    logic [AW-1:0]    last_clamp;
    logic             addr_ok;

    assign last_clamp = ({1'b0, cfg_last} >= STEPS_W) ? LAST_MAX : cfg_last;
    assign addr_ok    = ({1'b0, cfg_addr} < STEPS_W);

    // Reads happen combinationally at step entry, so a same-edge write loads the old entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                pat_tbl[i]   <= '0;
                dwell_tbl[i] <= '0;
            end
        end else if (cfg_we && addr_ok) begin
            pat_tbl[cfg_addr]   <= cfg_pattern;
            dwell_tbl[cfg_addr] <= cfg_dwell;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pattern_out <= IDLE_PAT;
            step_idx    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            dwell_cnt   <= '0;
            last_cur    <= '0;
        end else begin
            state       <= state_nxt;
            pattern_out <= pat_nxt;
            step_idx    <= idx_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            dwell_cnt   <= cnt_nxt;
            last_cur    <= last_nxt;
        end
    end

    // dwell_cnt is loaded with the entry's dwell and counts down; a step ends at zero.
    always_comb begin
        state_nxt = state;
        pat_nxt   = pattern_out;
        idx_nxt   = step_idx;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        cnt_nxt   = dwell_cnt;
        last_nxt  = last_cur;
        load      = 1'b0;
        load_idx  = '0;

        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    state_nxt = S_RUN;
                    load      = 1'b1;
                    last_nxt  = last_clamp;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                    pat_nxt   = IDLE_PAT;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                end else if (dwell_cnt != '0) begin
                    cnt_nxt = dwell_cnt - TW'(1);
                end else if (step_idx != last_cur) begin
                    load     = 1'b1;
                    load_idx = step_idx + AW'(1);
                end else if (loop_en) begin
                    load     = 1'b1;
                    last_nxt = last_clamp;
                end else begin
                    state_nxt = S_IDLE;
                    pat_nxt   = IDLE_PAT;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (load) begin
            pat_nxt  = pat_tbl[load_idx];
            cnt_nxt  = dwell_tbl[load_idx];
            idx_nxt  = load_idx;
            busy_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: timing, looping, stop, table writes, reset, clamp.
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_pattern;
    logic [31:0] cfg_dwell;
    logic [2:0]  cfg_last;
    logic        loop_en, start, stop;
    logic [15:0] pattern_out;
    logic [2:0]  step_idx;
    logic        busy, done;

    // Second instance with STEPS=3 exercises address filtering and cfg_last clamping.
    logic        c3_we;
    logic [1:0]  c3_addr;
    logic [15:0] c3_pattern;
    logic [31:0] c3_dwell;
    logic [1:0]  c3_last;
    logic        c3_start;
    logic [15:0] c3_pattern_out;
    logic [1:0]  c3_step_idx;
    logic        c3_busy, c3_done;

    led_pattern_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_pattern(cfg_pattern), .cfg_dwell(cfg_dwell), .cfg_last(cfg_last),
        .loop_en(loop_en), .start(start), .stop(stop),
        .pattern_out(pattern_out), .step_idx(step_idx), .busy(busy), .done(done)
    );

    led_pattern_sequencer #(.STEPS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(c3_we), .cfg_addr(c3_addr),
        .cfg_pattern(c3_pattern), .cfg_dwell(c3_dwell), .cfg_last(c3_last),
        .loop_en(1'b0), .start(c3_start), .stop(1'b0),
        .pattern_out(c3_pattern_out), .step_idx(c3_step_idx), .busy(c3_busy), .done(c3_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] p, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_pattern = p; cfg_dwell = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wr3(input logic [1:0] a, input logic [15:0] p, input logic [31:0] d);
        c3_we = 1'b1; c3_addr = a; c3_pattern = p; c3_dwell = d;
        tick();
        c3_we = 1'b0;
    endtask

    // Checks n consecutive cycles of a running step, ticking after each.
    task automatic expect_step(input string tag, input logic [15:0] p, input logic [2:0] idx, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_pat"}, pattern_out, p);
            check({tag, "_idx"}, step_idx, idx);
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_done"}, done, 1'b0);
            tick();
        end
    endtask

    task automatic expect_done(input string tag);
        check({tag, "_pat"}, pattern_out, 16'hFF0F);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_idx"}, step_idx, 3'd0);
        tick();
        check({tag, "_done_clr"}, done, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_pattern = '0; cfg_dwell = '0;
        cfg_last = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
        c3_we = 1'b0; c3_addr = '0; c3_pattern = '0; c3_dwell = '0; c3_last = '0; c3_start = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 100; i++) begin
            check("idle_pat", pattern_out, 16'hFF0F);
            check("idle_busy", busy, 1'b0);
            check("idle_done", done, 1'b0);
            tick();
        end
        check("idle_idx", step_idx, 3'd0);

        // 2: one-shot timing
        wr(3'd0, 16'hA001, 32'd5);
        wr(3'd1, 16'hB002, 32'd0);
        wr(3'd2, 16'hC003, 32'd2);
        cfg_last = 3'd2;
        pulse_start();
        expect_step("os_a", 16'hA001, 3'd0, 6);
        expect_step("os_b", 16'hB002, 3'd1, 1);
        expect_step("os_c", 16'hC003, 3'd2, 3);
        expect_done("os_end");

        // 3: looped playback, then clear loop_en mid-pass
        loop_en = 1'b1;
        pulse_start();
        for (int p = 0; p < 2; p++) begin
            expect_step("lp_a", 16'hA001, 3'd0, 6);
            expect_step("lp_b", 16'hB002, 3'd1, 1);
            expect_step("lp_c", 16'hC003, 3'd2, 3);
        end
        expect_step("lp_a3", 16'hA001, 3'd0, 3);
        loop_en = 1'b0;
        expect_step("lp_a3", 16'hA001, 3'd0, 3);
        expect_step("lp_b3", 16'hB002, 3'd1, 1);
        expect_step("lp_c3", 16'hC003, 3'd2, 3);
        expect_done("lp_end");

        // 4: stop 2 cycles into step 1; start&stop together in idle
        wr(3'd1, 16'hB002, 32'd4);
        pulse_start();
        expect_step("st_a", 16'hA001, 3'd0, 6);
        expect_step("st_b", 16'hB002, 3'd1, 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_pat", pattern_out, 16'hFF0F);
        check("stop_idx", step_idx, 3'd0);
        check("stop_busy", busy, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check("stop_nodone", done, 1'b0);
            tick();
        end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("ss_busy", busy, 1'b0);
        check("ss_pat", pattern_out, 16'hFF0F);
        tick();
        check("ss_busy2", busy, 1'b0);

        // 5: write to active entry, and same-cycle write at step entry
        loop_en = 1'b1;
        pulse_start();
        expect_step("wa_a", 16'hA001, 3'd0, 1);
        check("wa_a_pat2", pattern_out, 16'hA001);
        wr(3'd0, 16'h1234, 32'd1);
        expect_step("wa_a", 16'hA001, 3'd0, 4);
        expect_step("wa_b", 16'hB002, 3'd1, 5);
        expect_step("wa_c", 16'hC003, 3'd2, 2);
        check("wa_c_pat3", pattern_out, 16'hC003);
        wr(3'd0, 16'h5555, 32'd0);
        expect_step("wa_new", 16'h1234, 3'd0, 2);
        expect_step("wa_b2", 16'hB002, 3'd1, 5);
        expect_step("wa_c2", 16'hC003, 3'd2, 3);
        expect_step("wa_new2", 16'h5555, 3'd0, 1);
        expect_step("wa_b3", 16'hB002, 3'd1, 1);

        // 6: reset mid-run clears state and table
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_pat", pattern_out, 16'hFF0F);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_idx", step_idx, 3'd0);
        loop_en = 1'b0;
        cfg_last = 3'd2;
        pulse_start();
        expect_step("clr0", 16'h0000, 3'd0, 1);
        expect_step("clr1", 16'h0000, 3'd1, 1);
        expect_step("clr2", 16'h0000, 3'd2, 1);
        expect_done("clr_end");

        // clamp: STEPS=3, cfg_last=3 runs steps 0..2; write to addr 3 is dropped
        wr3(2'd0, 16'h0001, 32'd0);
        wr3(2'd1, 16'h0002, 32'd0);
        wr3(2'd2, 16'h0003, 32'd1);
        wr3(2'd3, 16'h0009, 32'd0);
        c3_last = 2'd3;
        c3_start = 1'b1;
        tick();
        c3_start = 1'b0;
        check("cl_p0", c3_pattern_out, 16'h0001);
        check("cl_i0", c3_step_idx, 2'd0);
        tick();
        check("cl_p1", c3_pattern_out, 16'h0002);
        tick();
        check("cl_p2a", c3_pattern_out, 16'h0003);
        check("cl_i2", c3_step_idx, 2'd2);
        tick();
        check("cl_p2b", c3_pattern_out, 16'h0003);
        check("cl_busy", c3_busy, 1'b1);
        tick();
        check("cl_end_pat", c3_pattern_out, 16'hFF0F);
        check("cl_end_done", c3_done, 1'b1);
        check("cl_end_busy", c3_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
